// File: rtl/product_collector.sv
// product_collector: result-side buffer for the multiplier path.
// It captures one product per rising edge of done_sig into a DEPTH-entry FIFO and lets a host
// pop results through a registered read port. The count, full and empty flags give the start
// controller back-pressure.
// Optional build macro PRODUCT_COLLECTOR_SEQ_TAG_EN tags every capture with a 4-bit sequence
// number. The tag is presented on seq_tag together with the popped word.
module product_collector #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done_sig,
    input  logic [DATA_W-1:0] product,
    input  logic              read_req,
    output logic [DATA_W-1:0] fifo_read_data,
    output logic              read_valid,
    output logic [ADDR_W:0]   count_sig,
    output logic              full_sig,
    output logic              empty_sig,
    output logic              overflow_sig
`ifdef PRODUCT_COLLECTOR_SEQ_TAG_EN
    ,
    output logic [3:0]        seq_tag
`endif
);

    // Pointer arithmetic relies on DEPTH == 2**ADDR_W so the pointers wrap for free.
    if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
        $error("product_collector: DEPTH must equal 2**ADDR_W");
    end

    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              done_q;

    logic              cap;
    logic              pop;
    logic              cap_accepted;
    logic              cap_dropped;
    logic [ADDR_W:0]   count_next;

`ifdef PRODUCT_COLLECTOR_SEQ_TAG_EN
    logic [3:0]        tag_mem [DEPTH];
    logic [3:0]        seq_cnt;
`endif

    // Flags and handshake decode. A pop on a full FIFO frees the slot that the write reuses,
    // so a simultaneous capture is still accepted.
    always_comb begin
        full_sig     = (count_sig == DEPTH_CNT);
        empty_sig    = (count_sig == '0);
        cap          = done_sig & ~done_q;
        pop          = read_req & ~empty_sig;
        cap_accepted = cap & (~full_sig | pop);
        cap_dropped  = cap & full_sig & ~pop;
    end

    // Occupancy bookkeeping: +1 on an accepted capture, -1 on a pop, unchanged on both.
    always_comb begin
        count_next = count_sig;
        case ({cap_accepted, pop})
            2'b10:   count_next = count_sig + CNT_ONE;
            2'b01:   count_next = count_sig - CNT_ONE;
            default: count_next = count_sig;
        endcase
    end

    // Storage write port. The array has no reset because the pointers define which words are
    // valid.
    always_ff @(posedge clk) begin
        if (cap_accepted) begin
            mem[wr_ptr] <= product;
        end
    end

    // Control state: edge detector, pointers, count, sticky overflow and the registered read
    // port.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q         <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count_sig      <= '0;
            fifo_read_data <= '0;
            read_valid     <= 1'b0;
            overflow_sig   <= 1'b0;
        end else begin
            done_q     <= done_sig;
            count_sig  <= count_next;
            read_valid <= pop;
            if (cap_accepted) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            // When the FIFO is full and a pop and a write happen together, wr_ptr == rd_ptr.
            // The non-blocking read returns the old word before it is overwritten.
            if (pop) begin
                fifo_read_data <= mem[rd_ptr];
                rd_ptr         <= rd_ptr + PTR_ONE;
            end
            if (cap_dropped) begin
                overflow_sig <= 1'b1;
            end
        end
    end

`ifdef PRODUCT_COLLECTOR_SEQ_TAG_EN
    // Tag storage, written alongside the data word.
    always_ff @(posedge clk) begin
        if (cap_accepted) begin
            tag_mem[wr_ptr] <= seq_cnt;
        end
    end

    // Sequence counter advances on every capture, dropped or not, so gaps expose lost results.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_cnt <= '0;
            seq_tag <= '0;
        end else begin
            if (cap) begin
                seq_cnt <= seq_cnt + 4'd1;
            end
            if (pop) begin
                seq_tag <= tag_mem[rd_ptr];
            end
        end
    end
`endif

endmodule

// File: tb/tb_product_collector.sv
// Self-checking bench for product_collector. A reference model decides on each cycle whether a
// capture or a pop happens. Accepted captures are pushed to a scoreboard queue, and every pop
// the model predicts is compared against the DUT's registered read port.
module tb_product_collector;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              rst;
    logic              done_sig;
    logic [DATA_W-1:0] product;
    logic              read_req;
    logic [DATA_W-1:0] fifo_read_data;
    logic              read_valid;
    logic [ADDR_W:0]   count_sig;
    logic              full_sig;
    logic              empty_sig;
    logic              overflow_sig;
`ifdef PRODUCT_COLLECTOR_SEQ_TAG_EN
    logic [3:0]        seq_tag;
`endif

    product_collector #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .done_sig       (done_sig),
        .product        (product),
        .read_req       (read_req),
        .fifo_read_data (fifo_read_data),
        .read_valid     (read_valid),
        .count_sig      (count_sig),
        .full_sig       (full_sig),
        .empty_sig      (empty_sig),
        .overflow_sig   (overflow_sig)
`ifdef PRODUCT_COLLECTOR_SEQ_TAG_EN
        ,
        .seq_tag        (seq_tag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard entries are {tag, data}.
    logic [19:0] sb [$];

    // Reference model state.
    int          m_count;
    logic        m_done_q;
    logic        m_ovf;
    logic [3:0]  m_seq;
    logic [15:0] m_data;
    logic [3:0]  m_tag;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock with the currently driven inputs, then compare all outputs to the model.
    task automatic step();
        logic        cap;
        logic        pop;
        logic        acc;
        logic [19:0] ent;
        cap = done_sig && !m_done_q;
        pop = read_req && (m_count != 0);
        acc = cap && ((m_count != DEPTH) || pop);
        if (rst) begin
            pop      = 1'b0;
            m_count  = 0;
            m_done_q = 1'b0;
            m_ovf    = 1'b0;
            m_seq    = 4'd0;
            m_data   = 16'd0;
            m_tag    = 4'd0;
            sb.delete();
        end else begin
            if (cap) begin
                if (acc) sb.push_back({m_seq, product});
                else m_ovf = 1'b1;
                m_seq = m_seq + 4'd1;
            end
            if (pop) begin
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", 1, 0);
                end else begin
                    ent    = sb.pop_front();
                    m_data = ent[15:0];
                    m_tag  = ent[19:16];
                end
            end
            m_count  = m_count + int'(acc) - int'(pop);
            m_done_q = done_sig;
        end
        @(posedge clk);
        #1;
        check_eq("read_valid", read_valid, pop);
        check_eq("read_data", fifo_read_data, m_data);
        check_eq("count", count_sig, m_count);
        check_eq("full", full_sig, m_count == DEPTH);
        check_eq("empty", empty_sig, m_count == 0);
        check_eq("overflow", overflow_sig, m_ovf);
`ifdef PRODUCT_COLLECTOR_SEQ_TAG_EN
        check_eq("seq_tag", seq_tag, m_tag);
`endif
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        done_sig = 1'b0;
        read_req = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // One done pulse (one cycle high, one cycle low).
    task automatic pulse(input logic [15:0] val);
        product  = val;
        done_sig = 1'b1;
        step();
        done_sig = 1'b0;
        step();
    endtask

    task automatic drain(input int n);
        read_req = 1'b1;
        repeat (n) step();
        read_req = 1'b0;
        step();
    endtask

    initial begin
        rst      = 1'b1;
        done_sig = 1'b0;
        read_req = 1'b0;
        product  = '0;
        m_count  = 0;
        m_done_q = 1'b0;
        m_ovf    = 1'b0;
        m_seq    = 4'd0;
        m_data   = 16'd0;
        m_tag    = 4'd0;

        // Reset state.
        do_reset();
        check_eq("rst_empty", empty_sig, 1);
        check_eq("rst_full", full_sig, 0);
        check_eq("rst_count", count_sig, 0);

        // A long done pulse produces a single capture.
        product  = 16'h00C8;
        done_sig = 1'b1;
        repeat (5) step();
        done_sig = 1'b0;
        step();
        check_eq("long_pulse_count", count_sig, 1);
        read_req = 1'b1;
        step();
        read_req = 1'b0;
        check_eq("long_pulse_valid", read_valid, 1);
        check_eq("long_pulse_data", fifo_read_data, 16'h00C8);
        step();

        // Fill the FIFO, overflow it, then drain it in order.
        for (int i = 1; i <= 16; i++) pulse(16'(i));
        check_eq("fill_full", full_sig, 1);
        check_eq("fill_count", count_sig, 16);
        check_eq("fill_no_ovf", overflow_sig, 0);
        pulse(16'd99);
        check_eq("ovf_set", overflow_sig, 1);
        check_eq("ovf_count", count_sig, 16);
        drain(16);
        check_eq("drain_empty", empty_sig, 1);

        // Capture and pop together while full: the write is accepted and no overflow occurs.
        do_reset();
        for (int i = 1; i <= 16; i++) pulse(16'(i));
        product  = 16'd77;
        done_sig = 1'b1;
        read_req = 1'b1;
        step();
        done_sig = 1'b0;
        read_req = 1'b0;
        step();
        check_eq("full_cap_pop_count", count_sig, 16);
        check_eq("full_cap_pop_ovf", overflow_sig, 0);
        drain(16);

        // A read on an empty FIFO is ignored, then a capture and a pop arrive in the same cycle.
        read_req = 1'b1;
        repeat (3) step();
        product  = 16'h1234;
        done_sig = 1'b1;
        step();
        check_eq("empty_cap_pop_count", count_sig, 1);
        done_sig = 1'b0;
        step();
        check_eq("empty_cap_pop_data", fifo_read_data, 16'h1234);
        read_req = 1'b0;
        step();

        // Wrap the pointers past the end of the array.
        for (int i = 0; i < 10; i++) pulse(16'h5000 + 16'(i));
        drain(10);
        for (int i = 0; i < 10; i++) pulse(16'hA000 + 16'(i));
        drain(10);
        check_eq("wrap_empty", empty_sig, 1);

        // Reset mid-operation while done_sig is high.
        for (int i = 0; i < 7; i++) pulse(16'h0700 + 16'(i));
        check_eq("pre_rst_count", count_sig, 7);
        done_sig = 1'b1;
        rst      = 1'b1;
        step();
        check_eq("mid_rst_count", count_sig, 0);
        check_eq("mid_rst_valid", read_valid, 0);
        check_eq("mid_rst_data", fifo_read_data, 0);
        // done_sig still high after reset release counts as a fresh edge.
        rst     = 1'b0;
        product = 16'h0BEE;
        step();
        done_sig = 1'b0;
        step();
        check_eq("post_rst_edge_count", count_sig, 1);
        drain(1);

`ifdef PRODUCT_COLLECTOR_SEQ_TAG_EN
        // A dropped capture leaves a gap in the tag sequence.
        do_reset();
        for (int i = 0; i < 16; i++) pulse(16'(i));
        pulse(16'hDEAD);
        drain(1);
        pulse(16'hBEEF);
        drain(15);
        check_eq("gap_prev_tag", seq_tag, 4'd15);
        drain(1);
        check_eq("gap_tag", seq_tag, 4'd1);
        check_eq("gap_data", fifo_read_data, 16'hBEEF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
